// File: rtl/axi_ss_arbiter.sv
// AXI4-Lite slave port bridged onto a simple request/grant slave bus.
// Single-entry AW/W/AR buffers feed a one-in-flight FSM with read/write round-robin.
module axi_ss_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                ss_req,
  output logic                ss_we,
  output logic [DATA_W/8-1:0] ss_be,
  output logic [ADDR_W-1:0]   ss_addr,
  output logic [DATA_W-1:0]   ss_wdata,
  input  logic                ss_gnt,
  input  logic                ss_rvalid,
  input  logic [DATA_W-1:0]   ss_rdata,
  input  logic                ss_err
);

  localparam int unsigned StrbW       = DATA_W / 8;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                aw_full_q, aw_full_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic                w_full_q, w_full_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [StrbW-1:0]    w_strb_q, w_strb_d;
  logic                ar_full_q, ar_full_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic                sel_wr_q, sel_wr_d;
  logic                last_wr_q, last_wr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic wr_pend, rd_pend, timed_out, resp_hs;

  always_comb begin
    wr_pend   = aw_full_q & w_full_q;
    rd_pend   = ar_full_q;
    timed_out = (cnt_q == TimeoutLast);
    resp_hs   = (state_q == StResp) & (sel_wr_q ? s_bready : s_rready);
  end

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    sel_wr_d  = sel_wr_q;
    last_wr_d = last_wr_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;

    // Buffers accept independently of the FSM so they can refill during a transfer.
    if (s_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (s_wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end
    if (s_arvalid && !ar_full_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_araddr;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_pend || rd_pend) begin
          // On a tie, serve the opposite of whatever completed last.
          sel_wr_d = wr_pend & (~rd_pend | ~last_wr_q);
          cnt_d    = '0;
          state_d  = StReq;
        end
      end
      StReq, StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (ss_rvalid && (ss_gnt || state_q == StWait)) begin
          state_d = StResp;
          resp_d  = ss_err ? 2'b10 : 2'b00;
          rdata_d = sel_wr_q ? '0 : ss_rdata;
        end else if (timed_out) begin
          state_d = StResp;
          resp_d  = 2'b10;
          rdata_d = '0;
        end else if (state_q == StReq && ss_gnt) begin
          state_d = StWait;
        end
      end
      StResp: begin
        if (resp_hs) begin
          state_d   = StIdle;
          last_wr_d = sel_wr_q;
          if (sel_wr_q) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
          end else begin
            ar_full_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      sel_wr_q  <= 1'b0;
      last_wr_q <= 1'b1;
      cnt_q     <= '0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      sel_wr_q  <= sel_wr_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Slave-side fields are zero outside REQ so the bus is quiet between requests.
  always_comb begin
    s_awready = ~aw_full_q;
    s_wready  = ~w_full_q;
    s_arready = ~ar_full_q;
    s_bvalid  = (state_q == StResp) & sel_wr_q;
    s_rvalid  = (state_q == StResp) & ~sel_wr_q;
    s_bresp   = resp_q;
    s_rresp   = resp_q;
    s_rdata   = rdata_q;
    s_rlast   = 1'b1;
    ss_req    = (state_q == StReq);
    ss_we     = ss_req & sel_wr_q;
    ss_addr   = '0;
    ss_be     = '0;
    ss_wdata  = '0;
    if (ss_req) begin
      ss_addr  = sel_wr_q ? aw_addr_q : ar_addr_q;
      ss_be    = sel_wr_q ? w_strb_q : '1;
      ss_wdata = sel_wr_q ? w_data_q : '0;
    end
  end

endmodule

// File: tb/tb_axi_ss_arbiter.sv
// Bench for axi_ss_arbiter: vector table plus directed multi-cycle sequences,
// responses checked against a scoreboard queue by a monitor.
module tb_axi_ss_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [31:0] ss_addr, ss_wdata, ss_rdata;
  logic [3:0]  s_wstrb, ss_be;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic        ss_req, ss_we, ss_gnt, ss_rvalid, ss_err;

  axi_ss_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .ss_req(ss_req), .ss_we(ss_we), .ss_be(ss_be), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
    .ss_gnt(ss_gnt), .ss_rvalid(ss_rvalid), .ss_rdata(ss_rdata), .ss_err(ss_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] sl_rdata;
    logic        sl_err;
    int          lat;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;

  // Slave model configuration and request log
  int          sl_lat = 0;
  int          sl_pend = 0;
  logic        sl_never = 1'b0;
  logic        sl_err = 1'b0;
  logic [31:0] sl_rdata = '0;
  int          req_cycles = 0;
  int          req_cyc = 0;
  logic        lg_we;
  logic [31:0] lg_addr, lg_wdata;
  logic [3:0]  lg_be;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave: grants on the first ss_req cycle, completes sl_lat cycles later.
  initial begin
    ss_gnt = 1'b0; ss_rvalid = 1'b0; ss_rdata = '0; ss_err = 1'b0;
    forever begin
      @(negedge clk);
      ss_gnt = 1'b0; ss_rvalid = 1'b0; ss_rdata = '0; ss_err = 1'b0;
      if (sl_pend > 0) begin
        sl_pend--;
        if (sl_pend == 0) begin
          ss_rvalid = 1'b1; ss_rdata = sl_rdata; ss_err = sl_err;
        end
      end
      if (ss_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          req_cyc = cyc; lg_we = ss_we; lg_addr = ss_addr; lg_be = ss_be; lg_wdata = ss_wdata;
        end
        if (!sl_never) begin
          ss_gnt = 1'b1;
          if (sl_lat == 0) begin
            ss_rvalid = 1'b1; ss_rdata = sl_rdata; ss_err = sl_err;
          end else begin
            sl_pend = sl_lat;
          end
        end
      end
    end
  end

  // Monitor: every AXI response handshake pops and checks one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((s_rvalid && s_rready) || (s_bvalid && s_bready)) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got bvalid=%0b rvalid=%0b expected none", s_bvalid,
                   s_rvalid);
        end else begin
          e = sb.pop_front();
          chk("resp_kind", s_bvalid, e.wr);
          if (e.wr) chk("bresp", s_bresp, e.resp);
          else begin
            chk("rresp", s_rresp, e.resp);
            chk("rdata", s_rdata, e.data);
            chk("rlast", s_rlast, 1'b1);
          end
        end
      end
    end
  end

  task automatic push(input logic wr, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.wr = wr; e.data = d; e.resp = r;
    sb.push_back(e);
  endtask

  // Raise the chosen valids; each drops after its handshake edge. Caller sits at posedge+1.
  task automatic drive(input bit ar, input bit aw, input bit w, input logic [31:0] ara,
                       input logic [31:0] awa, input logic [31:0] wd, input logic [3:0] ws,
                       output int hs);
    logic ra, rwa, rw;
    hs = 0;
    s_araddr = ara; s_arvalid = ar;
    s_awaddr = awa; s_awvalid = aw;
    s_wdata = wd; s_wstrb = ws; s_wvalid = w;
    for (int n = 0; n < 100 && (s_arvalid || s_awvalid || s_wvalid); n++) begin
      ra = s_arready; rwa = s_awready; rw = s_wready;
      @(posedge clk); #1;
      if (ra && s_arvalid) begin s_arvalid = 1'b0; hs = cyc; end
      if (rwa && s_awvalid) begin s_awvalid = 1'b0; hs = cyc; end
      if (rw && s_wvalid) begin s_wvalid = 1'b0; hs = cyc; end
    end
    if (s_arvalid || s_awvalid || s_wvalid) begin
      total++; bad++;
      $display("FAIL addr_handshake: got no ready expected handshake within 100 cycles");
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int target);
    for (int n = 0; n < 200 && resp_cnt < target; n++) begin
      @(posedge clk); #1;
    end
    chk("resp_arrived", resp_cnt >= target, 1'b1);
  endtask

  task automatic wait_valid(input bit wr);
    for (int n = 0; n < 100 && !(wr ? s_bvalid : s_rvalid); n++) begin
      @(posedge clk); #1;
    end
    chk("valid_seen", wr ? s_bvalid : s_rvalid, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  vec_t vec[6];
  int   hs, rc;

  initial begin
    vec[0] = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hdead_beef, 1'b0, 0, 4'hF, 32'h0,
               32'hdead_beef, 2'b00};
    vec[1] = '{1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 4'hF, 32'h0,
               32'h1234_5678, 2'b00};
    vec[2] = '{1'b0, 32'h0000_300c, 32'h0, 4'h0, 32'ha5a5_a5a5, 1'b1, 1, 4'hF, 32'h0,
               32'ha5a5_a5a5, 2'b10};
    vec[3] = '{1'b1, 32'h8000_0010, 32'hcafe_f00d, 4'h3, 32'h0, 1'b0, 0, 4'h3, 32'hcafe_f00d,
               32'h0, 2'b00};
    vec[4] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b1, 2, 4'hF, 32'h1122_3344,
               32'h0, 2'b10};
    vec[5] = '{1'b1, 32'h0000_0040, 32'h0, 4'h8, 32'h0, 1'b0, 5, 4'h8, 32'h0, 32'h0, 2'b00};

    reset = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_awready", s_awready, 1'b1);
    chk("rst_wready", s_wready, 1'b1);
    chk("rst_arready", s_arready, 1'b1);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_resp", {s_bresp, s_rresp}, 4'h0);
    chk("rst_rdata", s_rdata, 32'h0);
    chk("rst_ss_req", {ss_req, ss_we}, 2'b00);
    chk("rst_ss_fields", {ss_be, ss_addr, ss_wdata}, 68'h0);

    // Minimum-latency read
    sl_lat = 0; sl_rdata = 32'h41; sl_err = 1'b0; req_cycles = 0;
    push(1'b0, 32'h41, 2'b00); rc = resp_cnt;
    drive(1, 0, 0, 32'h9a10_0000, 32'h0, 32'h0, 4'h0, hs);
    wait_resp(rc + 1);
    chk("lat_req_cycles", req_cycles, 1);
    chk("lat_req_cycle", req_cyc, hs + 1);
    chk("lat_rvalid_cycle", resp_cyc, hs + 2);
    chk("lat_ss_addr", lg_addr, 32'h9a10_0000);
    chk("lat_ss_rd_fields", {lg_we, lg_be, lg_wdata}, {1'b0, 4'hF, 32'h0});

    // Vector table, one transaction at a time
    for (int i = 0; i < 6; i++) begin
      sl_lat = vec[i].lat; sl_rdata = vec[i].sl_rdata; sl_err = vec[i].sl_err;
      req_cycles = 0; rc = resp_cnt;
      push(vec[i].wr, vec[i].exp_rdata, vec[i].exp_resp);
      if (vec[i].wr) drive(0, 1, 1, 32'h0, vec[i].addr, vec[i].wdata, vec[i].strb, hs);
      else drive(1, 0, 0, vec[i].addr, 32'h0, 32'h0, 4'h0, hs);
      wait_resp(rc + 1);
      chk("vec_req_cycles", req_cycles, 1);
      chk("vec_ss_we", lg_we, vec[i].wr);
      chk("vec_ss_addr", lg_addr, vec[i].addr);
      chk("vec_ss_be", lg_be, vec[i].exp_be);
      chk("vec_ss_wdata", lg_wdata, vec[i].exp_wdata);
    end

    // AW two cycles ahead of W
    sl_lat = 0; sl_err = 1'b0; req_cycles = 0; rc = resp_cnt;
    drive(0, 1, 0, 32'h0, 32'h8000_1000, 32'h0, 4'h0, hs);
    chk("aw_buffer_full", s_awready, 1'b0);
    @(posedge clk); #1;
    chk("no_req_without_w", req_cycles, 0);
    push(1'b1, 32'h0, 2'b00);
    drive(0, 0, 1, 32'h0, 32'h0, 32'h1, 4'hF, hs);
    wait_resp(rc + 1);
    chk("split_req_cycles", req_cycles, 1);
    chk("split_ss_fields", {lg_we, lg_be, lg_addr, lg_wdata}, {1'b1, 4'hF, 32'h8000_1000, 32'h1});

    // Simultaneous read and write after reset: read first, then alternate
    do_reset();
    for (int k = 0; k < 2; k++) begin
      sl_lat = 0; sl_rdata = 32'h77 + k; req_cycles = 0; rc = resp_cnt;
      push(1'b0, 32'h77 + k, 2'b00);
      push(1'b1, 32'h0, 2'b00);
      drive(1, 1, 1, 32'h100 + k, 32'h200 + k, 32'h300 + k, 4'hF, hs);
      wait_resp(rc + 2);
      chk("tie_first_is_read", lg_we, 1'b0);
      chk("tie_req_cycles", req_cycles, 2);
    end

    // AR accepted while a write response is stalled
    s_bready = 1'b0; sl_lat = 0; rc = resp_cnt;
    push(1'b1, 32'h0, 2'b00);
    drive(0, 1, 1, 32'h0, 32'h400, 32'hface, 4'h1, hs);
    wait_valid(1'b1);
    sl_rdata = 32'h66;
    push(1'b0, 32'h66, 2'b00);
    drive(1, 0, 0, 32'h500, 32'h0, 32'h0, 4'h0, hs);
    chk("ar_refill_accepted", s_arready, 1'b0);
    chk("bvalid_held", s_bvalid, 1'b1);
    chk("no_req_during_resp", ss_req, 1'b0);
    s_bready = 1'b1;
    wait_resp(rc + 2);

    // s_rready low for five cycles
    s_rready = 1'b0; sl_rdata = 32'h5a5a_0001; req_cycles = 0; rc = resp_cnt;
    push(1'b0, 32'h5a5a_0001, 2'b00);
    drive(1, 0, 0, 32'h600, 32'h0, 32'h0, 4'h0, hs);
    wait_valid(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", s_rvalid, 1'b1);
      chk("stall_rdata", s_rdata, 32'h5a5a_0001);
      chk("stall_ar_held", s_arready, 1'b0);
      chk("stall_no_req", ss_req, 1'b0);
    end
    @(posedge clk); #1 s_rready = 1'b1;
    wait_resp(rc + 1);
    chk("stall_req_cycles", req_cycles, 1);

    // Slave never answers
    sl_never = 1'b1; sl_rdata = 32'hffff_ffff; req_cycles = 0; rc = resp_cnt;
    push(1'b0, 32'h0, 2'b10);
    drive(1, 0, 0, 32'h700, 32'h0, 32'h0, 4'h0, hs);
    wait_resp(rc + 1);
    chk("to_req_cycles", req_cycles, 16);
    chk("to_resp_delay", resp_cyc - req_cyc, 16);
    sl_never = 1'b0;

    // Reset during WAIT, then a late slave completion must be ignored
    sl_lat = 10; sl_rdata = 32'h99; req_cycles = 0;
    drive(1, 0, 0, 32'h800, 32'h0, 32'h0, 4'h0, hs);
    for (int n = 0; n < 50 && req_cycles == 0; n++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valids", {s_rvalid, s_bvalid}, 2'b00);
    chk("mid_rst_readys", {s_awready, s_wready, s_arready}, 3'b111);
    chk("mid_rst_ss", {ss_req, ss_we, ss_be, ss_addr, ss_wdata}, 70'h0);
    chk("mid_rst_data", {s_rdata, s_rresp, s_bresp}, 36'h0);
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    rc = resp_cnt;
    repeat (12) @(posedge clk);
    #1 chk("late_rvalid_ignored", resp_cnt, rc);
    sl_lat = 0; sl_rdata = 32'h55; req_cycles = 0;
    push(1'b0, 32'h55, 2'b00);
    drive(1, 0, 0, 32'h900, 32'h0, 32'h0, 4'h0, hs);
    wait_resp(rc + 1);
    chk("post_rst_req_addr", lg_addr, 32'h900);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_ss_arbiter.md
AXI_SS_ARBITER -- requirements
Module: axi_ss_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (byte strobes DATA_W/8).
REQ-003 SHALL have parameter TIMEOUT, default 256, slave no-response limit in cycles (1..65535).
REQ-004 SHALL have ports:
 clk  in  1  single clock, rising edge.
 reset  in  1  asynchronous, active-high.
 s_awaddr  in  ADDR_W  write address.
 s_awvalid / s_awready  in / out  1  write address handshake.
 s_wdata  in  DATA_W  write data.
 s_wstrb  in  DATA_W/8  write byte strobes.
 s_wvalid / s_wready  in / out  1  write data handshake.
 s_bresp  out  2  write response.
 s_bvalid / s_bready  out / in  1  write response handshake.
 s_araddr  in  ADDR_W  read address.
 s_arvalid / s_arready  in / out  1  read address handshake.
 s_rdata  out  DATA_W  read data.
 s_rresp  out  2  read response.
 s_rlast  out  1  constant 1 (single beat).
 s_rvalid / s_rready  out / in  1  read data handshake.
 ss_req  out  1  simple-slave request.
 ss_we  out  1  1=write, 0=read.
 ss_be  out  DATA_W/8  byte enables.
 ss_addr  out  ADDR_W  slave address.
 ss_wdata  out  DATA_W  slave write data.
 ss_gnt  in  1  slave accepted request.
 ss_rvalid  in  1  slave completion (reads and writes).
 ss_rdata  in  DATA_W  slave read data, valid with ss_rvalid.
 ss_err  in  1  slave error, valid with ss_rvalid.

Function
REQ-005 SHALL hold three single-entry buffers AW, W, AR; s_awready=!aw_full, s_wready=!w_full, s_arready=!ar_full; a buffer fills on valid&ready.
REQ-006 SHALL treat a write as pending when aw_full&w_full, a read as pending when ar_full.
REQ-007 SHALL implement FSM IDLE, REQ, WAIT, RESP; one transaction in flight at a time.
REQ-008 IDLE: if only one pending, select it; if both, select opposite of last_sel (round-robin); none -> stay IDLE; next state REQ.
REQ-009 REQ: ss_req=1 with ss_we/ss_addr/ss_wdata/ss_be stable from selected buffer; reads drive ss_be all-ones, ss_wdata 0; ss_gnt -> WAIT.
REQ-010 WAIT: ss_req=0; ss_rvalid -> RESP, register ss_rdata (reads) and resp=ss_err?2'b10:2'b00.
REQ-011 SHALL accept ss_rvalid in the same cycle as ss_gnt (REQ -> RESP directly).
REQ-012 RESP: assert s_rvalid (read) or s_bvalid (write) with registered resp/data; hold until s_rready/s_bready; on handshake free the selected buffers (AR, or AW+W), update last_sel, go IDLE.
REQ-013 Minimum latency: AR handshake at edge N -> ss_req high cycle N+2 -> with ss_gnt&ss_rvalid at N+2, s_rvalid high cycle N+3.
REQ-014 SHALL count cycles spent in REQ+WAIT (16-bit, clears on entering REQ); at TIMEOUT cycles without completion go RESP with resp=2'b10, s_rdata=0, ss_req deasserted.
REQ-015 SHALL allow buffers to refill while another transaction is in flight (e.g. new AR accepted during write RESP).
REQ-016 Outputs s_rdata/s_rresp/s_bresp SHALL be stable while their valid is high and awaiting ready.

Reset
REQ-017 On reset: FSM=IDLE, all buffers empty, last_sel=write (read wins first tie), counter=0.
REQ-018 Reset values: s_awready=s_wready=s_arready=1 after release; s_bvalid=s_rvalid=0, s_bresp=s_rresp=0, s_rdata=0, ss_req=ss_we=0, ss_be/ss_addr/ss_wdata=0.
REQ-019 Reset mid-transaction SHALL drop the transaction without any response; a late ss_rvalid after reset in IDLE SHALL be ignored.

Verification
REQ-020 Read 0x9a100000, slave gnt+rvalid same cycle, data 0x41 -> ss_req one cycle, s_rvalid with s_rdata=0x41, s_rresp=0, latency per REQ-013.
REQ-021 Write 0x80001000 data 0x1 strb 0xF, AW two cycles before W -> single ss_req with ss_we=1, ss_be=0xF, s_bvalid with s_bresp=0.
REQ-022 AR and AW+W both pending after reset -> read served first, then write; repeat simultaneous -> read,write alternate.
REQ-023 s_rready held low 5 cycles -> s_rvalid/s_rdata stable 5 cycles, AR buffer not freed, no new ss_req.
REQ-024 Slave never answers, TIMEOUT=16 -> RESP after 16 cycles, s_rresp=2'b10, s_rdata=0; ss_err=1 on write -> s_bresp=2'b10.
REQ-025 Reset asserted during WAIT -> all outputs at REQ-018 values immediately; next read completes normally.
